// File: rtl/func_call_unit_pkg.sv
// Shared op encodings and field widths for the function-call unit.
package func_call_unit_pkg;

    localparam int FCU_OP_W = 2;

    typedef enum logic [FCU_OP_W-1:0] {
        FCU_ADD      = 2'd0,
        FCU_SUB      = 2'd1,
        FCU_RAND_ADD = 2'd2,
        FCU_XOR      = 2'd3
    } fcu_op_e;

endpackage

// File: rtl/fcu_rr_arbiter.sv
// Round-robin grant: lowest requester at or above ptr_i, wrapping to index 0.
module fcu_rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req_valid_i,
    input  logic [CH_W-1:0]     ptr_i,
    output logic [CHANNELS-1:0] grant_o,
    output logic [CH_W-1:0]     grant_idx_o
);

    logic [CHANNELS-1:0] masked_s;
    logic [CHANNELS-1:0] pick_s;
    logic                found_s;

    // Keep only requesters at or above the pointer.
    always_comb begin
        masked_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            masked_s[i] = req_valid_i[i] & (i >= int'(ptr_i));
        end
    end

    // Lowest set bit of the masked set, or of the full set when the mask is empty.
    always_comb begin
        pick_s      = (|masked_s) ? masked_s : req_valid_i;
        grant_o     = '0;
        grant_idx_o = '0;
        found_s     = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_o[i]  = pick_s[i] & ~found_s;
            grant_idx_o = grant_idx_o | (CH_W'(i) & {CH_W{grant_o[i]}});
            found_s     = found_s | pick_s[i];
        end
    end

endmodule

// File: rtl/func_call_unit.sv
// Function-call engine: round-robin arbitration over CHANNELS callers feeding a
// fixed-latency two-operand datapath whose results carry the caller id.
module func_call_unit
    import func_call_unit_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 2,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          req_valid,
    output logic [CHANNELS-1:0]          req_ready,
    input  logic [FCU_OP_W*CHANNELS-1:0] req_op,
    input  logic [WIDTH*CHANNELS-1:0]    req_a,
    input  logic [WIDTH*CHANNELS-1:0]    req_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_flag,
    output logic [CH_W-1:0]              out_id,
    output logic                         busy
);

    // Result is {flag, data}; the extra top bit is carry for adds and borrow for SUB.
    function automatic logic [WIDTH:0] fcu_compute(input fcu_op_e op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (op)
            FCU_ADD:      r = {1'b0, a} + {1'b0, b};
            FCU_SUB:      r = {1'b0, a} - {1'b0, b};
            FCU_RAND_ADD: r = {{WIDTH{1'b0}}, &a} + {1'b0, b};
            FCU_XOR:      r = {1'b0, a ^ b};
            default:      r = '0;
        endcase
        return r;
    endfunction

    logic [CH_W-1:0]     ptr_q;
    logic [CH_W-1:0]     ptr_d;
    logic [CHANNELS-1:0] grant_s;
    logic [CH_W-1:0]     gidx_s;
    logic                stall_s;
    logic                accept_s;
    fcu_op_e             sel_op_s;
    logic [WIDTH-1:0]    sel_a_s;
    logic [WIDTH-1:0]    sel_b_s;
    logic [WIDTH:0]      res_s;

    // Stage chain: index 0 is the stage-1 input, index LATENCY the output stage.
    logic [LATENCY:0]    vld_c_s;
    logic [LATENCY:0]    flag_c_s;
    logic [WIDTH-1:0]    data_c_s [LATENCY+1];
    logic [CH_W-1:0]     id_c_s   [LATENCY+1];

    fcu_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_arb (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant_s),
        .grant_idx_o (gidx_s)
    );

    assign stall_s   = vld_c_s[LATENCY] & ~out_ready;
    assign req_ready = grant_s & {CHANNELS{~stall_s & ~rst}};
    assign accept_s  = |req_ready;

    assign sel_op_s = fcu_op_e'(req_op[gidx_s*FCU_OP_W +: FCU_OP_W]);
    assign sel_a_s  = req_a[gidx_s*WIDTH +: WIDTH];
    assign sel_b_s  = req_b[gidx_s*WIDTH +: WIDTH];
    assign res_s    = fcu_compute(sel_op_s, sel_a_s, sel_b_s);

    assign vld_c_s[0]  = accept_s;
    assign flag_c_s[0] = res_s[WIDTH];
    assign data_c_s[0] = res_s[WIDTH-1:0];
    assign id_c_s[0]   = gidx_s;

    // Pointer moves just past the granted channel.
    always_comb begin
        if (gidx_s == CH_W'(CHANNELS - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gidx_s + CH_W'(1);
        end
    end

    // Round-robin pointer updates only when a call is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_s) begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic             vld_q;
        logic             flag_q;
        logic [WIDTH-1:0] data_q;
        logic [CH_W-1:0]  id_q;

        // Stage register: the whole pipe freezes while the output is stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                flag_q <= 1'b0;
                data_q <= '0;
                id_q   <= '0;
            end else if (!stall_s) begin
                vld_q  <= vld_c_s[s];
                flag_q <= flag_c_s[s];
                data_q <= data_c_s[s];
                id_q   <= id_c_s[s];
            end
        end

        assign vld_c_s[s+1]  = vld_q;
        assign flag_c_s[s+1] = flag_q;
        assign data_c_s[s+1] = data_q;
        assign id_c_s[s+1]   = id_q;
    end

    assign out_valid = vld_c_s[LATENCY];
    assign out_flag  = flag_c_s[LATENCY];
    assign out_data  = data_c_s[LATENCY];
    assign out_id    = id_c_s[LATENCY];
    assign busy      = |vld_c_s[LATENCY:1];

endmodule

// File: tb/tb_func_call_unit.sv
// Directed bench: default 8-bit/4-channel/2-stage unit plus a 1-bit/1-channel/1-stage unit.
module tb_func_call_unit;
    import func_call_unit_pkg::*;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int CW = 2;

    // {op[1:0], a, b, exp_data, exp_flag} for the 1-bit instance
    localparam logic [5:0] V1 [5] = '{6'b001101, 6'b010111, 6'b101010, 6'b111100, 6'b001010};

    logic             clk = 1'b0;
    logic             rst;
    logic [C-1:0]     req_valid;
    logic [C-1:0]     req_ready;
    logic [2*C-1:0]   req_op;
    logic [W*C-1:0]   req_a;
    logic [W*C-1:0]   req_b;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_flag;
    logic [CW-1:0]    out_id;
    logic             busy;

    logic             r1_valid;
    logic             r1_ready;
    logic [1:0]       r1_op;
    logic             r1_a;
    logic             r1_b;
    logic             o1_valid;
    logic             o1_ready;
    logic             o1_data;
    logic             o1_flag;
    logic             o1_id;
    logic             o1_busy;

    int n_checks = 0;
    int n_errors = 0;

    func_call_unit #(.WIDTH(W), .CHANNELS(C), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .out_id    (out_id),
        .busy      (busy)
    );

    func_call_unit #(.WIDTH(1), .CHANNELS(1), .LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (r1_valid),
        .req_ready (r1_ready),
        .req_op    (r1_op),
        .req_a     (r1_a),
        .req_b     (r1_b),
        .out_valid (o1_valid),
        .out_ready (o1_ready),
        .out_data  (o1_data),
        .out_flag  (o1_flag),
        .out_id    (o1_id),
        .busy      (o1_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[ch*2 +: 2] = op;
        req_a[ch*W +: W]  = a;
        req_b[ch*W +: W]  = b;
    endtask

    task automatic single_call(input string tag, input int ch, input logic [1:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] exp_data, input logic exp_flag);
        req_valid     = '0;
        req_valid[ch] = 1'b1;
        set_req(ch, op, a, b);
        #1;
        check_eq({tag, "_ready"}, req_ready, 32'(1) << ch);
        tick();
        req_valid = '0;
        check_eq({tag, "_early"}, out_valid, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b1);
        tick();
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_data"}, out_data, exp_data);
        check_eq({tag, "_flag"}, out_flag, exp_flag);
        check_eq({tag, "_id"}, out_id, ch);
        tick();
        check_eq({tag, "_gone"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [5:0] vec;
        rst = 1'b1; out_ready = 1'b1; req_op = '0; req_a = '0; req_b = '0;
        r1_valid = 1'b0; r1_op = 2'd0; r1_a = 1'b0; r1_b = 1'b0; o1_ready = 1'b1;
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        check_eq("rst_ready", req_ready, 4'h0);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_data", out_data, 8'h00);
        check_eq("rst_flag", out_flag, 1'b0);
        check_eq("rst_id", out_id, 2'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_valid1", o1_valid, 1'b0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single calls; pointer walks 0 -> 1 -> 3 -> 2 -> 0 -> 1
        single_call("add_ch0", 0, 2'd0, 8'hFF, 8'h01, 8'h00, 1'b1);
        single_call("sub_ch2", 2, 2'd1, 8'h03, 8'h05, 8'hFE, 1'b1);
        single_call("radd_ch1", 1, 2'd2, 8'hFF, 8'h01, 8'h02, 1'b0);
        single_call("xor_ch3", 3, 2'd3, 8'hA5, 8'h0F, 8'hAA, 1'b0);
        single_call("sub_ch0", 0, 2'd1, 8'h05, 8'h03, 8'h02, 1'b0);

        // Two calls in flight, then reset
        req_valid = 4'b0110;
        set_req(1, 2'd0, 8'h10, 8'h01);
        set_req(2, 2'd0, 8'h20, 8'h01);
        #1;
        check_eq("inflight_rdy0", req_ready, 4'b0010);
        tick();
        check_eq("inflight_rdy1", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check_eq("inflight_busy", busy, 1'b1);
        check_eq("inflight_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_valid", out_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("midrst_lost", out_valid, 1'b0);
        end

        // All channels requesting: grants and ids 0,1,2,3,0,1,2,3
        for (int ch = 0; ch < C; ch++) set_req(ch, 2'd0, 8'(ch*16 + 1), 8'h01);
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            check_eq("rr_ready", req_ready, (k < 8) ? (32'(1) << (k % 4)) : 32'(0));
            if (k >= 2 && k < 10) begin
                check_eq("rr_valid", out_valid, 1'b1);
                check_eq("rr_id", out_id, (k - 2) % 4);
                check_eq("rr_data", out_data, ((k - 2) % 4) * 16 + 2);
            end else begin
                check_eq("rr_idle", out_valid, 1'b0);
            end
            tick();
        end

        // Backpressure with the pipe full, then drain
        for (int ch = 0; ch < C; ch++) set_req(ch, 2'd3, 8'(ch), 8'hF0);
        out_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        check_eq("st_rdy0", req_ready, 4'b0001);
        tick();
        check_eq("st_rdy1", req_ready, 4'b0010);
        tick();
        for (int k = 0; k < 5; k++) begin
            check_eq("st_ready", req_ready, 4'b0000);
            check_eq("st_valid", out_valid, 1'b1);
            check_eq("st_id", out_id, 2'd0);
            check_eq("st_data", out_data, 8'hF0);
            check_eq("st_flag", out_flag, 1'b0);
            check_eq("st_busy", busy, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_eq("rel_ready", req_ready, 4'b0100);
        check_eq("rel_id0", out_id, 2'd0);
        tick();
        req_valid = '0;
        check_eq("rel_valid1", out_valid, 1'b1);
        check_eq("rel_id1", out_id, 2'd1);
        check_eq("rel_data1", out_data, 8'hF1);
        tick();
        check_eq("rel_valid2", out_valid, 1'b1);
        check_eq("rel_id2", out_id, 2'd2);
        check_eq("rel_data2", out_data, 8'hF2);
        tick();
        check_eq("rel_empty", out_valid, 1'b0);
        check_eq("rel_busy", busy, 1'b0);

        // 1-bit, single-channel, single-stage instance, back to back
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                vec      = V1[k];
                r1_valid = 1'b1;
                r1_op    = vec[5:4];
                r1_a     = vec[3];
                r1_b     = vec[2];
            end else begin
                r1_valid = 1'b0;
            end
            #1;
            check_eq("w1_ready", r1_ready, (k < 5) ? 32'(1) : 32'(0));
            if (k >= 1) begin
                vec = V1[k-1];
                check_eq("w1_valid", o1_valid, 1'b1);
                check_eq("w1_data", o1_data, vec[1]);
                check_eq("w1_flag", o1_flag, vec[0]);
                check_eq("w1_id", o1_id, 1'b0);
            end else begin
                check_eq("w1_idle", o1_valid, 1'b0);
            end
            tick();
        end
        check_eq("w1_empty", o1_valid, 1'b0);
        check_eq("w1_busy", o1_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
